// File: rtl/collision_pkg.sv
// Shared constants and clamp helpers for the collision probe.
// Latency: none (package only).
// Backpressure: not applicable.
package collision_pkg;

    localparam int N_DIR     = 4;
    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    // Tile indices 1 and 18 are solid unless a level overrides the mask.
    localparam logic [63:0] SOLID_MASK_DFLT = 64'h0000_0000_0004_0002;

    // Clamp a signed bound so it never goes below zero.
    function automatic logic signed [13:0] floor_zero(input logic signed [13:0] v);
        return (v < 14'sd0) ? 14'sd0 : v;
    endfunction

    // Clamp a signed bound so it never exceeds lim.
    function automatic logic signed [13:0] ceil_at(input logic signed [13:0] v,
                                                   input logic signed [13:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/collision_probe_if.sv
// Pixel-stream and result bundle between the video pipeline and the collision probe.
// Latency: none (wiring only).
// Backpressure: none; the pixel stream is free-running.
interface collision_probe_if;

    logic [10:0]                     hcount_in;
    logic [9:0]                      vcount_in;
    logic [12:0]                     x_center_in;
    logic [9:0]                      y_center_in;
    logic [11:0]                     offset_in;
    logic                            new_frame_in;
    logic [5:0]                      tile_index_in;
    logic [collision_pkg::N_DIR-1:0] collision_live_out;
    logic [collision_pkg::N_DIR-1:0] collision_flags_out;
    logic                            collision_valid_out;

    modport master (
        output hcount_in, vcount_in, x_center_in, y_center_in, offset_in,
               new_frame_in, tile_index_in,
        input  collision_live_out, collision_flags_out, collision_valid_out
    );

    modport slave (
        input  hcount_in, vcount_in, x_center_in, y_center_in, offset_in,
               new_frame_in, tile_index_in,
        output collision_live_out, collision_flags_out, collision_valid_out
    );

endinterface

// File: rtl/collision_edge_compare.sv
// Clamped hitbox bounds and per-pixel edge test against a solid tile.
// Latency: combinational.
// Backpressure: none.
module collision_edge_compare
    import collision_pkg::*;
#(
    parameter int                HALF_W       = 4,
    parameter int                HALF_H       = 16,
    parameter int                WORLD_X_MAX  = 3375,
    parameter int                SCREEN_Y_MAX = 239,
    parameter logic [63:0]       SOLID_MASK   = SOLID_MASK_DFLT,
    parameter logic [N_DIR-1:0]  DIR_EN       = 4'b1111
) (
    input  logic [12:0]          x_center,
    input  logic [9:0]           y_center,
    input  logic [12:0]          world_x,
    input  logic [9:0]           vcount,
    input  logic                 active,
    input  logic [5:0]           tile_index,
    output logic [N_DIR-1:0]     hit
);

    localparam logic signed [13:0] HW   = 14'(HALF_W);
    localparam logic signed [13:0] HH   = 14'(HALF_H);
    localparam logic signed [13:0] XMAX = 14'(WORLD_X_MAX);
    localparam logic signed [13:0] YMAX = 14'(SCREEN_Y_MAX);

    logic signed [13:0] x_l, x_r, y_u, y_d;
    logic signed [13:0] wx, vy;
    logic               in_x, in_y;
    logic [N_DIR-1:0]   raw;

    // Hitbox edges from the frame snapshot, clamped to the world/screen.
    always_comb begin
        x_l = floor_zero($signed({1'b0, x_center}) - HW);
        x_r = ceil_at($signed({1'b0, x_center}) + HW, XMAX);
        y_u = floor_zero($signed({4'b0, y_center}) - HH);
        y_d = ceil_at($signed({4'b0, y_center}) + HH, YMAX);
    end

    // Edge membership of the current pixel, qualified by activity, solidity and enables.
    always_comb begin
        wx   = $signed({1'b0, world_x});
        vy   = $signed({4'b0, vcount});
        in_x = (wx >= x_l) && (wx <= x_r);
        in_y = (vy >= y_u) && (vy <= y_d);
        raw  = '0;
        raw[DIR_UP]    = (vy == y_u) && in_x;
        raw[DIR_DOWN]  = (vy == y_d) && in_x;
        raw[DIR_LEFT]  = (wx == x_l) && in_y;
        raw[DIR_RIGHT] = (wx == x_r) && in_y;
        hit = '0;
        if (active && SOLID_MASK[tile_index]) begin
            hit = raw & DIR_EN;
        end
    end

endmodule

// File: rtl/collision_probe.sv
// Per-pixel hitbox-edge collision detector with per-frame sticky flag summary.
// Latency: live hit TILE_LAT+1 cycles after hcount/vcount; flags/valid one cycle after new_frame_in.
// Backpressure: none; consumes one pixel every cycle.
module collision_probe
    import collision_pkg::*;
#(
    parameter int               HALF_W       = 4,
    parameter int               HALF_H       = 16,
    parameter int               WORLD_X_MAX  = 3375,
    parameter int               SCREEN_Y_MAX = 239,
    parameter int               ACTIVE_W     = 320,
    parameter int               ACTIVE_H     = 240,
    parameter int               TILE_LAT     = 2,   // must be at least 1
    parameter logic [63:0]      SOLID_MASK   = SOLID_MASK_DFLT,
    parameter logic [N_DIR-1:0] DIR_EN       = 4'b1111
) (
    input logic               pixel_clk_in,
    input logic               rst_in,
    collision_probe_if.slave  bus
);

    logic [12:0]                 xc_snap;
    logic [9:0]                  yc_snap;
    logic [11:0]                 off_snap;
    logic [TILE_LAT-1:0][10:0]   h_pipe;
    logic [TILE_LAT-1:0][9:0]    v_pipe;
    logic [TILE_LAT-1:0]         act_pipe;
    logic                        active_now;
    logic [12:0]                 world_x;
    logic [N_DIR-1:0]            hit;
    logic [N_DIR-1:0]            live_q;
    logic [N_DIR-1:0]            acc_q;
    logic [N_DIR-1:0]            flags_q;
    logic                        valid_q;

    assign active_now = (bus.hcount_in < 11'(ACTIVE_W)) && (bus.vcount_in < 10'(ACTIVE_H));
    assign world_x    = {2'b0, h_pipe[TILE_LAT-1]} + {1'b0, off_snap};

    // Player position and scroll are frozen at frame start so a frame is judged consistently.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            xc_snap  <= '0;
            yc_snap  <= '0;
            off_snap <= '0;
        end else if (bus.new_frame_in) begin
            xc_snap  <= bus.x_center_in;
            yc_snap  <= bus.y_center_in;
            off_snap <= bus.offset_in;
        end
    end

    // Delay pixel coordinates so they line up with the late tile lookup.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            h_pipe   <= '0;
            v_pipe   <= '0;
            act_pipe <= '0;
        end else begin
            h_pipe[0]   <= bus.hcount_in;
            v_pipe[0]   <= bus.vcount_in;
            act_pipe[0] <= active_now;
            for (int i = 1; i < TILE_LAT; i++) begin
                h_pipe[i]   <= h_pipe[i-1];
                v_pipe[i]   <= v_pipe[i-1];
                act_pipe[i] <= act_pipe[i-1];
            end
        end
    end

    collision_edge_compare #(
        .HALF_W       (HALF_W),
        .HALF_H       (HALF_H),
        .WORLD_X_MAX  (WORLD_X_MAX),
        .SCREEN_Y_MAX (SCREEN_Y_MAX),
        .SOLID_MASK   (SOLID_MASK),
        .DIR_EN       (DIR_EN)
    ) u_cmp (
        .x_center   (xc_snap),
        .y_center   (yc_snap),
        .world_x    (world_x),
        .vcount     (v_pipe[TILE_LAT-1]),
        .active     (act_pipe[TILE_LAT-1]),
        .tile_index (bus.tile_index_in),
        .hit        (hit)
    );

    // Register the per-pixel hit.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            live_q <= '0;
        end else begin
            live_q <= hit;
        end
    end

    // Sticky accumulation; the live hit seen during new_frame_in still belongs to the closing frame.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            acc_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else if (bus.new_frame_in) begin
            flags_q <= acc_q | live_q;
            acc_q   <= '0;
            valid_q <= 1'b1;
        end else begin
            acc_q   <= acc_q | live_q;
            valid_q <= 1'b0;
        end
    end

    assign bus.collision_live_out  = live_q;
    assign bus.collision_flags_out = flags_q;
    assign bus.collision_valid_out = valid_q;

endmodule

// File: tb/tb_collision_probe.sv
module tb_collision_probe;

    localparam int          LAT  = 2;
    localparam int          NC   = 4096;
    localparam logic [63:0] MASK = 64'h0000_0000_0004_0002;

    logic        pixel_clk_in;
    logic        rst_in;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [12:0] x_center;
    logic [9:0]  y_center;
    logic [11:0] offset;
    logic        new_frame;
    logic [5:0]  tile_index;

    collision_probe_if bus0 ();
    collision_probe_if bus1 ();

    assign bus0.hcount_in = hcount;      assign bus1.hcount_in = hcount;
    assign bus0.vcount_in = vcount;      assign bus1.vcount_in = vcount;
    assign bus0.x_center_in = x_center;  assign bus1.x_center_in = x_center;
    assign bus0.y_center_in = y_center;  assign bus1.y_center_in = y_center;
    assign bus0.offset_in = offset;      assign bus1.offset_in = offset;
    assign bus0.new_frame_in = new_frame; assign bus1.new_frame_in = new_frame;
    assign bus0.tile_index_in = tile_index; assign bus1.tile_index_in = tile_index;

    collision_probe dut0 (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .bus          (bus0.slave)
    );

    collision_probe #(.DIR_EN(4'b0001)) dut1 (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .bus          (bus1.slave)
    );

    initial begin
        pixel_clk_in = 1'b0;
        forever #5 pixel_clk_in = ~pixel_clk_in;
    end

    // Stimulus plan, one entry per clock edge; tile for a pixel sits LAT entries later.
    int h_p [NC];
    int v_p [NC];
    int t_p [NC];
    int xc_p [NC];
    int yc_p [NC];
    int off_p [NC];
    bit nf_p [NC];
    bit rst_p [NC];
    int dl_p [2][NC];   // directed live expectation, -1 = none
    int df_p [2][NC];   // directed flags expectation, -1 = none
    int pc;
    int cur_xc, cur_yc, cur_off;
    int sn_xc, sn_yc, sn_off;
    int n_vec, n_err, now_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, now_cyc, obs, exp);
        end
    endtask

    task automatic step(input int h, input int v, input int tile, input bit nf, input bit rs);
        h_p[pc] = h; v_p[pc] = v; t_p[pc + LAT] = tile;
        nf_p[pc] = nf; rst_p[pc] = rs;
        xc_p[pc] = cur_xc; yc_p[pc] = cur_yc; off_p[pc] = cur_off;
        if (rs) begin
            sn_xc = 0; sn_yc = 0; sn_off = 0;
        end else if (nf) begin
            sn_xc = cur_xc; sn_yc = cur_yc; sn_off = cur_off;
        end
        pc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(400, 300, 0, 1'b0, 1'b0);
    endtask

    task automatic frame(output int idx);
        idx = pc;
        step(400, 300, 0, 1'b1, 1'b0);
    endtask

    // Place a pixel and record the directed live expectation for both instances.
    task automatic px(input int h, input int v, input int tile, input int e0, input int e1);
        dl_p[0][pc + LAT] = e0;
        dl_p[1][pc + LAT] = e1;
        step(h, v, tile, 1'b0, 1'b0);
    endtask

    // Hit set of one pixel straight from the geometric rules.
    function automatic logic [3:0] live_of(input int h, input int v, input int tile,
                                           input int xc, input int yc, input int off,
                                           input logic [3:0] en);
        logic [63:0] mask;
        logic [3:0]  r;
        int wx, xl, xr, yu, yd;
        mask = MASK;
        r  = 4'b0;
        wx = h + off;
        xl = (xc - 4 < 0) ? 0 : xc - 4;
        xr = (xc + 4 > 3375) ? 3375 : xc + 4;
        yu = (yc - 16 < 0) ? 0 : yc - 16;
        yd = (yc + 16 > 239) ? 239 : yc + 16;
        if (h < 320 && v < 240 && mask[tile] == 1'b1) begin
            if (v == yu && wx >= xl && wx <= xr) r[0] = 1'b1;
            if (v == yd && wx >= xl && wx <= xr) r[1] = 1'b1;
            if (wx == xl && v >= yu && v <= yd) r[2] = 1'b1;
            if (wx == xr && v >= yu && v <= yd) r[3] = 1'b1;
        end
        return r & en;
    endfunction

    // Expected live output just after edge n.
    function automatic logic [3:0] exp_live(input int n, input logic [3:0] en);
        int e, j, sx, sy, so;
        e = n - LAT;
        if (e < 0) return 4'b0;
        for (int k = e; k <= n; k++) if (rst_p[k]) return 4'b0;
        j = n - 1;
        while (j >= 0 && !rst_p[j] && !nf_p[j]) j--;
        sx = 0; sy = 0; so = 0;
        if (j >= 0 && !rst_p[j]) begin
            sx = xc_p[j]; sy = yc_p[j]; so = off_p[j];
        end
        return live_of(h_p[e], v_p[e], t_p[n], sx, sy, so, en);
    endfunction

    task automatic rand_step();
        int xl, xr, yu, yd, wx, v, h, tsel, tile;
        xl = (sn_xc - 4 < 0) ? 0 : sn_xc - 4;
        xr = (sn_xc + 4 > 3375) ? 3375 : sn_xc + 4;
        yu = (sn_yc - 16 < 0) ? 0 : sn_yc - 16;
        yd = (sn_yc + 16 > 239) ? 239 : sn_yc + 16;
        wx = int'($urandom_range(xr, xl));
        v  = int'($urandom_range(yd, yu));
        case ($urandom_range(5, 0))
            0: v = yu;
            1: v = yd;
            2: wx = xl;
            3: wx = xr;
            default: begin
                wx = sn_off + int'($urandom_range(340, 0));
                v  = int'($urandom_range(250, 0));
            end
        endcase
        h = wx - sn_off;
        if (h < 0 || h > 2047) h = 400;
        tsel = int'($urandom_range(3, 0));
        tile = (tsel == 0) ? 1 : (tsel == 1) ? 18 : (tsel == 2) ? 5 : int'($urandom_range(63, 0));
        step(h, v, tile, 1'b0, 1'b0);
    endtask

    logic [3:0] en [2];
    logic [3:0] fo [2];
    logic [3:0] lp [2];
    logic [3:0] ef [2];
    logic [3:0] el [2];
    logic       ev [2];
    logic [3:0] obs_l, obs_f;
    logic       obs_v;
    int         fi, e;

    initial begin
        n_vec = 0; n_err = 0; now_cyc = 0; pc = 0;
        cur_xc = 0; cur_yc = 0; cur_off = 0; sn_xc = 0; sn_yc = 0; sn_off = 0;
        for (int i = 0; i < NC; i++) begin
            h_p[i] = 400; v_p[i] = 300; t_p[i] = 0; xc_p[i] = 0; yc_p[i] = 0; off_p[i] = 0;
            nf_p[i] = 1'b0; rst_p[i] = 1'b0;
            dl_p[0][i] = -1; dl_p[1][i] = -1; df_p[0][i] = -1; df_p[1][i] = -1;
        end

        // Reset state.
        for (int i = 0; i < 3; i++) begin
            dl_p[0][pc] = 0; dl_p[1][pc] = 0; df_p[0][pc] = 0; df_p[1][pc] = 0;
            step(400, 300, 0, 1'b0, 1'b1);
        end
        idle(2);

        // Up hit.
        cur_xc = 100; cur_yc = 120; cur_off = 0;
        frame(fi); df_p[0][fi] = 0; df_p[1][fi] = 0;
        px(100, 104, 1, 4'b0001, 4'b0001);
        idle(6);
        frame(fi); df_p[0][fi] = 4'b0001; df_p[1][fi] = 4'b0001;
        // Back-to-back frame reports an empty frame.
        frame(fi); df_p[0][fi] = 0; df_p[1][fi] = 0;

        // Left clamp at world x 0; right bound is 6.
        cur_xc = 2; cur_yc = 120; cur_off = 0;
        frame(fi); df_p[0][fi] = 0; df_p[1][fi] = 0;
        px(0, 120, 18, 4'b0100, 4'b0000);
        px(7, 120, 18, 4'b0000, 4'b0000);
        idle(4);

        // Non-solid tile on every edge.
        cur_xc = 100; cur_yc = 120; cur_off = 0;
        frame(fi); df_p[0][fi] = 4'b0100; df_p[1][fi] = 0;
        px(100, 104, 5, 0, 0);
        px(100, 136, 5, 0, 0);
        px(96, 120, 5, 0, 0);
        px(104, 120, 5, 0, 0);
        idle(4);

        // Solid tile on the right edge but outside the active area.
        cur_xc = 326; cur_yc = 120; cur_off = 0;
        frame(fi); df_p[0][fi] = 0; df_p[1][fi] = 0;
        px(330, 120, 1, 0, 0);
        idle(4);

        // Bottom clamp to the last screen row.
        cur_xc = 100; cur_yc = 230; cur_off = 0;
        frame(fi); df_p[0][fi] = 0; df_p[1][fi] = 0;
        px(100, 239, 1, 4'b0010, 4'b0000);
        idle(4);

        // Hit coinciding with new_frame_in belongs to the closing frame.
        cur_xc = 100; cur_yc = 120; cur_off = 0;
        frame(fi); df_p[0][fi] = 4'b0010; df_p[1][fi] = 0;
        px(100, 104, 1, 4'b0001, 4'b0001);
        idle(LAT);
        frame(fi); df_p[0][fi] = 4'b0001; df_p[1][fi] = 4'b0001;
        idle(5);
        frame(fi); df_p[0][fi] = 0; df_p[1][fi] = 0;

        // Reset mid-frame discards accumulation, including a hit still in flight.
        px(100, 104, 1, 4'b0001, 4'b0001);
        px(100, 136, 1, 4'b0010, 4'b0000);
        idle(3);
        e = pc;
        px(100, 104, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            df_p[0][pc] = 0; df_p[1][pc] = 0;
            step(400, 300, 0, 1'b0, 1'b1);
        end
        idle(8);
        frame(fi); df_p[0][fi] = 0; df_p[1][fi] = 0;

        // All four edges hit; second instance only reports up.
        px(100, 104, 1, 4'b0001, 4'b0001);
        px(100, 136, 1, 4'b0010, 4'b0000);
        px(96, 120, 1, 4'b0100, 4'b0000);
        px(104, 120, 1, 4'b1000, 4'b0000);
        idle(5);
        frame(fi); df_p[0][fi] = 4'b1111; df_p[1][fi] = 4'b0001;

        // Randomized frames aimed at the hitbox edges.
        for (int f = 0; f < 50; f++) begin
            cur_xc  = int'($urandom_range(3375, 0));
            cur_yc  = int'($urandom_range(239, 0));
            cur_off = (cur_xc >= 200) ? cur_xc - 200 + int'($urandom_range(150, 0))
                                      : int'($urandom_range(cur_xc, 0));
            if ($urandom_range(15, 0) == 0) step(400, 300, 0, 1'b0, 1'b1);
            frame(fi);
            for (int s = 0; s < 30; s++) begin
                if ($urandom_range(7, 0) == 0) begin
                    cur_xc = int'($urandom_range(3375, 0));
                    cur_yc = int'($urandom_range(239, 0));
                end
                rand_step();
            end
        end
        frame(fi);
        idle(LAT + 2);

        en[0] = 4'b1111; en[1] = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            fo[k] = 4'b0; lp[k] = 4'b0; ef[k] = 4'b0; ev[k] = 1'b0;
        end

        for (int n = 0; n < pc; n++) begin
            now_cyc    = n;
            rst_in     = rst_p[n];
            new_frame  = nf_p[n];
            hcount     = 11'(h_p[n]);
            vcount     = 10'(v_p[n]);
            tile_index = 6'(t_p[n]);
            x_center   = 13'(xc_p[n]);
            y_center   = 10'(yc_p[n]);
            offset     = 12'(off_p[n]);
            @(posedge pixel_clk_in);
            #1;
            for (int k = 0; k < 2; k++) begin
                el[k] = exp_live(n, en[k]);
                if (rst_p[n]) begin
                    fo[k] = 4'b0; ef[k] = 4'b0; ev[k] = 1'b0;
                end else if (nf_p[n]) begin
                    ef[k] = fo[k] | lp[k]; fo[k] = 4'b0; ev[k] = 1'b1;
                end else begin
                    fo[k] = fo[k] | lp[k]; ev[k] = 1'b0;
                end
                lp[k] = el[k];
                obs_l = (k == 0) ? bus0.collision_live_out  : bus1.collision_live_out;
                obs_f = (k == 0) ? bus0.collision_flags_out : bus1.collision_flags_out;
                obs_v = (k == 0) ? bus0.collision_valid_out : bus1.collision_valid_out;
                chk($sformatf("live%0d", k),  32'(obs_l), 32'(el[k]));
                chk($sformatf("flags%0d", k), 32'(obs_f), 32'(ef[k]));
                chk($sformatf("valid%0d", k), 32'(obs_v), 32'(ev[k]));
                if (dl_p[k][n] >= 0) chk($sformatf("dir_live%0d", k), 32'(obs_l), 32'(dl_p[k][n]));
                if (df_p[k][n] >= 0) chk($sformatf("dir_flags%0d", k), 32'(obs_f), 32'(df_p[k][n]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/collision_probe.md
COLLISION_PROBE -- requirements
Module: collision_probe

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- HALF_W, 4: hitbox half-width, world pixels.
- HALF_H, 16: hitbox half-height, screen lines.
- WORLD_X_MAX, 3375: last valid world x.
- SCREEN_Y_MAX, 239: last valid screen y.
- ACTIVE_W, 320: active pixels per line.
- ACTIVE_H, 240: active lines.
- TILE_LAT, 2: tile_index_in delay, in cycles, behind hcount_in/vcount_in.
- SOLID_MASK, 64'h0000_0000_0004_0002: bit k set means tile index k is solid.
- DIR_EN, 4'b1111: per-direction enable {right,left,down,up}.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- pixel_clk_in, in, 1: single clock.
- rst_in, in, 1: synchronous, active-high reset.
- hcount_in, in, 11: screen x.
- vcount_in, in, 10: screen y.
- x_center_in, in, 13: player centre, world x.
- y_center_in, in, 10: player centre, screen y.
- offset_in, in, 12: camera scroll.
- new_frame_in, in, 1: one-cycle frame-start pulse.
- tile_index_in, in, 6: tile index at the delayed pixel.
- collision_live_out, out, 4: per-pixel hit {R,L,D,U}.
- collision_flags_out, out, 4: previous frame's accumulated hits {R,L,D,U}.
- collision_valid_out, out, 1: one-cycle pulse when collision_flags_out updates.

Function
REQ-003 On new_frame_in, x_center_in, y_center_in and offset_in SHALL be captured into frame snapshots; all comparisons in the following frame SHALL use only the snapshots.
REQ-004 hcount_in, vcount_in and the active-region qualifier (hcount_in < ACTIVE_W && vcount_in < ACTIVE_H) SHALL be delayed TILE_LAT cycles so they align with tile_index_in.
REQ-005 World x SHALL be the 13-bit unsigned sum of the delayed hcount and offset snapshot; no wrap can occur within legal ranges.
REQ-006 Bounds SHALL be computed in signed 14-bit arithmetic and clamped:
- x_l = max(xc-HALF_W, 0)
- x_r = min(xc+HALF_W, WORLD_X_MAX)
- y_u = max(yc-HALF_H, 0)
- y_d = min(yc+HALF_H, SCREEN_Y_MAX)
REQ-007 A pixel SHALL count as a hit only when it is active and SOLID_MASK[tile_index_in] = 1.
REQ-008 Direction hit rules SHALL be:
- U: vcount == y_u and x_l <= world_x <= x_r.
- D: vcount == y_d and x in the same range.
- L: world_x == x_l and y_u <= vcount <= y_d.
- R: world_x == x_r and the same vcount range.
Each direction SHALL be gated by DIR_EN.
REQ-009 collision_live_out SHALL be registered, valid TILE_LAT+1 cycles after the corresponding hcount_in/vcount_in.
REQ-010 Each bit of collision_live_out SHALL OR into a sticky per-direction accumulator.
REQ-011 On new_frame_in, collision_flags_out SHALL load accumulator OR current live hit, the accumulators SHALL clear, and collision_valid_out SHALL pulse on the next cycle; a hit coinciding with new_frame_in belongs to the closing frame.
REQ-012 Back-to-back new_frame_in pulses SHALL each produce a valid pulse; a pulse after an empty frame SHALL report flags 4'b0000.
REQ-013 Clamp boundary: with xc < HALF_W, x_l SHALL be 0 and L SHALL fire at world_x 0; with yc > SCREEN_Y_MAX-HALF_H, D SHALL test row SCREEN_Y_MAX.

Reset
REQ-014 While rst_in is high at a clock edge, all outputs, snapshots, accumulators and delay pipelines SHALL clear to 0.
REQ-015 Reset mid-frame SHALL discard partial accumulation, and no valid pulse SHALL occur until the next new_frame_in after reset.

Structure
REQ-016 The shared package collision_pkg SHALL hold the direction index constants (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3) and the default SOLID_MASK.
REQ-017 Bound computation plus per-pixel compare SHALL live in the sub-module collision_edge_compare; the top SHALL own the snapshots, delay pipelines, accumulators and frame latch.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Up hit: xc=100, yc=120, offset=0, tile 1 at (100,104) -> live U at TILE_LAT+1; flags=4'b0001 with valid pulse after next new_frame.
- Clamp: xc=2, tile 18 at (0,120) -> L set and x_l=0; tile 18 at (7,120) -> no R, since x_r=6.
- Non-solid and inactive: tile 5 on every edge -> flags 0; tile 1 at hcount 330 -> no hit.
- Simultaneous: hit pixel coincident with new_frame_in -> counted in closing frame; new frame's flags 0.
- Reset mid-frame: hits then rst_in -> outputs 0; no valid pulse until the next new_frame_in.
- DIR_EN=4'b0001 with hits on all four edges -> flags 4'b0001.
